instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//   IF stage of the 16-bit 5-stage pipeline. Holds the PC and drives the instruction memory
//   address combinationally. Latches the returned word into the IF/ID pipeline register.
//   Handles hazard-unit stalls, EX-stage branch/jump redirects and the HALT stop condition.
//   Consumer of the instruction memory output; producer for the decode stage.
// PARAMETERS
//   RESET_PC     16'h0000  PC value loaded on reset
//   HALT_OPCODE  5'd1      opcode (instr[15:11]) that stops fetching
//   NOP_WORD     16'h0000  bubble word injected into IF/ID (NOP opcode, zero operands)
// PORTS
//   clock        in   1   rising-edge clock
//   r_st         in   1   reset; synchronous, active-high
//   stall        in   1   hazard unit: hold PC and IF/ID register
//   redirect     in   1   EX stage: branch/jump taken
//   redirect_pc  in   16  target address, valid when redirect=1
//   i_addr       out  16  address to instruction memory (= PC, combinational)
//   i_data       in   16  instruction word from memory (combinational read of i_addr)
//   id_instr     out  16  IF/ID instruction register
//   id_pc        out  16  address id_instr was fetched from
//   id_valid     out  1   1 = id_instr is a real fetched word; 0 = bubble
//   halted       out  1   1 = fetch stopped on HALT
//   fetch_count  out  16  number of words latched into IF/ID since reset; wraps mod 2^16
// BEHAVIOUR
//   - State machine: RUN, HALTED. All state updates occur on the rising edge of clock.
//   - Reset (r_st=1 at an edge; overrides everything, including mid-operation):
//       state=RUN, pc=RESET_PC, id_instr=NOP_WORD, id_pc=0, id_valid=0, halted=0, fetch_count=0.
//   - i_addr = pc at all times, with no added latency. id_* lags i_addr by exactly one cycle.
//   - Per-edge priority: r_st > redirect > stall > normal operation.
//   - redirect=1 (either state, stall ignored):
//       pc<=redirect_pc; id_instr<=NOP_WORD; id_valid<=0; id_pc<=pc.
//       state<=RUN; halted<=0; fetch_count held.
//       The wrong-path word currently on i_data is discarded.
//   - stall=1, no redirect (either state):
//       pc, id_instr, id_pc, id_valid, fetch_count, state and halted all hold.
//   - RUN, no stall, no redirect:
//       id_instr<=i_data; id_pc<=pc; id_valid<=1; fetch_count<=fetch_count+1.
//       If i_data[15:11]==HALT_OPCODE: pc holds, state<=HALTED, halted<=1.
//         halted rises on the same edge that HALT enters id_instr.
//       Otherwise: pc<=pc+1, wrapping 16'hFFFF -> 16'h0000.
//   - HALTED, no stall, no redirect:
//       pc holds; id_instr<=NOP_WORD; id_valid<=0; id_pc<=pc; fetch_count holds.
//       HALT therefore occupies IF/ID for exactly one un-stalled cycle, followed by bubbles.
//   - Leaving HALTED: only via redirect or r_st.
//   - Memory contents are not checked here; any 16-bit word is latched as-is.
// TESTING
//   1 Reset, release; mem[0..3]=ADD words:
//       i_addr 0,1,2,3 on successive cycles; id_pc 0,1,2 one cycle later;
//       id_valid=1 from first post-reset edge; fetch_count increments by 1 per cycle.
//   2 Running at pc=5, stall=1 for 2 cycles:
//       i_addr stays 5; id_instr/id_pc/fetch_count frozen; resumes with pc=6 after release.
//   3 stall=1 and redirect=1 to 16'h001C on the same edge:
//       next cycle i_addr=0x001C, id_instr=0x0000, id_valid=0 (redirect wins).
//   4 mem[31]=16'h0800 (HALT) reached:
//       id_instr=0x0800, halted=1, i_addr stuck at 31;
//       following cycles id_instr=0x0000, id_valid=0, fetch_count constant.
//   5 While HALTED, redirect to 0x0005:
//       halted=0 next edge, i_addr=5, then 6.
//     Separately, redirect to 0xFFFF: i_addr sequence 0xFFFF then 0x0000.
//   6 r_st pulsed mid-run at pc=9 with stall=1:
//       next edge i_addr=RESET_PC, id_valid=0, halted=0, fetch_count=0.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage for the 16-bit 5-stage pipeline.
// Holds the PC and drives the instruction memory address directly from it.
// Fills the IF/ID register with the fetched word, or with a bubble on redirect or after HALT.
module instruction_fetch #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [4:0]  HALT_OPCODE = 5'd1,
    parameter logic [15:0] NOP_WORD    = 16'h0000
) (
    input  logic        clock,
    input  logic        r_st,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] i_addr,
    input  logic [15:0] i_data,
    output logic [15:0] id_instr,
    output logic [15:0] id_pc,
    output logic        id_valid,
    output logic        halted,
    output logic [15:0] fetch_count
);

    typedef enum logic {RUN, HALTED} state_t;

    state_t      state;
    logic [15:0] pc;

    // Memory address is the live PC; the read comes back in the same cycle.
    assign i_addr = pc;

    // Fetch FSM: priority is reset, then redirect, then stall, then normal fetch.
    always_ff @(posedge clock) begin
        if (r_st) begin
            state       <= RUN;
            pc          <= RESET_PC;
            id_instr    <= NOP_WORD;
            id_pc       <= 16'h0000;
            id_valid    <= 1'b0;
            halted      <= 1'b0;
            fetch_count <= 16'h0000;
        end else if (redirect) begin
            // The word on i_data is from the wrong path, so a bubble goes down instead.
            state    <= RUN;
            pc       <= redirect_pc;
            id_instr <= NOP_WORD;
            id_pc    <= pc;
            id_valid <= 1'b0;
            halted   <= 1'b0;
        end else if (!stall) begin
            case (state)
                RUN: begin
                    id_instr    <= i_data;
                    id_pc       <= pc;
                    id_valid    <= 1'b1;
                    fetch_count <= fetch_count + 16'd1;
                    if (i_data[15:11] == HALT_OPCODE) begin
                        // HALT enters IF/ID on this edge; the PC parks on it.
                        state  <= HALTED;
                        halted <= 1'b1;
                    end else begin
                        pc <= pc + 16'd1;
                    end
                end
                HALTED: begin
                    id_instr <= NOP_WORD;
                    id_pc    <= pc;
                    id_valid <= 1'b0;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a small behavioural instruction memory
// (ADD-like words 0x1000|addr, HALT at address 31) and hand-computed expectations.
module tb_instruction_fetch;

    logic        clock = 1'b0;
    logic        r_st;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] i_addr;
    logic [15:0] i_data;
    logic [15:0] id_instr;
    logic [15:0] id_pc;
    logic        id_valid;
    logic        halted;
    logic [15:0] fetch_count;

    logic [15:0] mem [0:63];

    int n_cmp = 0;
    int n_err = 0;

    instruction_fetch dut (
        .clock       (clock),
        .r_st        (r_st),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .i_addr      (i_addr),
        .i_data      (i_data),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_valid    (id_valid),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    always #5 clock = ~clock;

    // Combinational memory read of the low address bits.
    assign i_data = mem[i_addr[5:0]];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h1000 | 16'(i);
        mem[31] = 16'h0800;

        r_st = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        step(); step();
        chk("rst_addr", i_addr, 16'h0000);
        chk("rst_instr", id_instr, 16'h0000);
        chk("rst_valid", {15'd0, id_valid}, 16'd0);
        chk("rst_halted", {15'd0, halted}, 16'd0);
        chk("rst_count", fetch_count, 16'd0);

        // 1: sequential fetch
        r_st = 1'b0;
        #1 chk("t1_addr0", i_addr, 16'h0000);
        step();
        chk("t1_addr1", i_addr, 16'h0001);
        chk("t1_idpc0", id_pc, 16'h0000);
        chk("t1_instr0", id_instr, 16'h1000);
        chk("t1_valid", {15'd0, id_valid}, 16'd1);
        chk("t1_count1", fetch_count, 16'd1);
        step();
        chk("t1_addr2", i_addr, 16'h0002);
        chk("t1_idpc1", id_pc, 16'h0001);
        chk("t1_count2", fetch_count, 16'd2);
        step();
        chk("t1_addr3", i_addr, 16'h0003);
        chk("t1_idpc2", id_pc, 16'h0002);
        chk("t1_count3", fetch_count, 16'd3);

        // 2: stall at pc=5
        step(); step();
        chk("t2_addr5", i_addr, 16'h0005);
        chk("t2_count5", fetch_count, 16'd5);
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            chk("t2_stall_addr", i_addr, 16'h0005);
            chk("t2_stall_idpc", id_pc, 16'h0004);
            chk("t2_stall_instr", id_instr, 16'h1004);
            chk("t2_stall_count", fetch_count, 16'd5);
        end
        stall = 1'b0;
        step();
        chk("t2_resume_addr", i_addr, 16'h0006);
        chk("t2_resume_idpc", id_pc, 16'h0005);
        chk("t2_resume_instr", id_instr, 16'h1005);
        chk("t2_resume_count", fetch_count, 16'd6);

        // 3: redirect beats stall
        stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h001C;
        step();
        chk("t3_addr", i_addr, 16'h001C);
        chk("t3_instr", id_instr, 16'h0000);
        chk("t3_valid", {15'd0, id_valid}, 16'd0);
        chk("t3_idpc", id_pc, 16'h0006);
        chk("t3_count", fetch_count, 16'd6);
        stall = 1'b0; redirect = 1'b0;

        // 4: run into HALT at 31
        step(); step(); step();
        chk("t4_addr31", i_addr, 16'd31);
        chk("t4_count9", fetch_count, 16'd9);
        step();
        chk("t4_halt_instr", id_instr, 16'h0800);
        chk("t4_halt_valid", {15'd0, id_valid}, 16'd1);
        chk("t4_halted", {15'd0, halted}, 16'd1);
        chk("t4_halt_addr", i_addr, 16'd31);
        chk("t4_halt_count", fetch_count, 16'd10);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("t4_bub_instr", id_instr, 16'h0000);
            chk("t4_bub_valid", {15'd0, id_valid}, 16'd0);
            chk("t4_bub_addr", i_addr, 16'd31);
            chk("t4_bub_idpc", id_pc, 16'd31);
            chk("t4_bub_count", fetch_count, 16'd10);
            chk("t4_bub_halted", {15'd0, halted}, 16'd1);
        end

        // 5: leave HALTED via redirect, then wrap from 0xFFFF
        redirect = 1'b1; redirect_pc = 16'h0005;
        step();
        chk("t5_halted", {15'd0, halted}, 16'd0);
        chk("t5_addr5", i_addr, 16'h0005);
        chk("t5_valid", {15'd0, id_valid}, 16'd0);
        chk("t5_count", fetch_count, 16'd10);
        redirect = 1'b0;
        step();
        chk("t5_addr6", i_addr, 16'h0006);
        chk("t5_instr", id_instr, 16'h1005);
        chk("t5_count11", fetch_count, 16'd11);
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        step();
        chk("t5_addr_ffff", i_addr, 16'hFFFF);
        redirect = 1'b0;
        step();
        chk("t5_addr_wrap", i_addr, 16'h0000);
        chk("t5_idpc_ffff", id_pc, 16'hFFFF);
        chk("t5_instr_ffff", id_instr, 16'h103F);
        chk("t5_count12", fetch_count, 16'd12);

        // 6: reset mid-run at pc=9 with stall asserted
        redirect = 1'b1; redirect_pc = 16'h0009;
        step();
        chk("t6_addr9", i_addr, 16'h0009);
        redirect = 1'b0; stall = 1'b1; r_st = 1'b1;
        step();
        chk("t6_addr", i_addr, 16'h0000);
        chk("t6_valid", {15'd0, id_valid}, 16'd0);
        chk("t6_halted", {15'd0, halted}, 16'd0);
        chk("t6_count", fetch_count, 16'd0);
        chk("t6_instr", id_instr, 16'h0000);
        r_st = 1'b0; stall = 1'b0;
        step();
        chk("t6_post_addr", i_addr, 16'h0001);
        chk("t6_post_count", fetch_count, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
